rd_contrl: RTL and testbench

Read-side pointer/flag controller of the asynchronous FIFO. It is the read-domain counterpart of the write controller. It consumes the write controller's Gray write pointer after an external 2-FF synchroniser into r_clk, and drives the shared dual-port memory read address. It generates the registered empty flag, an occupancy count, an almost-empty flag and a sticky underflow error. It also returns its own Gray read pointer to the write domain for the full comparison.

---
 rtl/rd_contrl.sv | 67 ++++++
 tb/tb_rd_contrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rd_contrl.sv
// Read-side pointer/flag controller of the asynchronous FIFO: read pointer,
// memory read address, empty/almost-empty flags, occupancy and sticky underflow.
module rd_contrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int AE_LEVEL   = 2
) (
   input  logic                  r_clk,
   input  logic                  r_rst,
   input  logic                  rinc,
   output logic                  rempty,
   output logic                  ralmost_empty,
   output logic [ADDR_WIDTH:0]   rcount,
   output logic                  runderflow,
   input  logic                  runderflow_clr,
   output logic [ADDR_WIDTH:0]   r_ptr,
   input  logic [ADDR_WIDTH:0]   w_ptr_sync,
   output logic [ADDR_WIDTH-1:0] raddr
);

   localparam logic [ADDR_WIDTH:0] AE_THRESH = AE_LEVEL[ADDR_WIDTH:0];

   logic                pop;
   logic [ADDR_WIDTH:0] rbin;
   logic [ADDR_WIDTH:0] rbin_next;
   logic [ADDR_WIDTH:0] rgray_next;
   logic [ADDR_WIDTH:0] wbin_sync;
   logic [ADDR_WIDTH:0] count_next;

   assign pop        = rinc & ~rempty;
   assign rbin_next  = rbin + {{ADDR_WIDTH{1'b0}}, pop};
   assign rgray_next = (rbin_next >> 1) ^ rbin_next;
   assign raddr      = rbin[ADDR_WIDTH-1:0];

   // Gray-to-binary: bit i is the XOR of all Gray bits at or above i.
   always_comb begin
      wbin_sync = '0;
      for (int unsigned i = 0; i <= ADDR_WIDTH; i++) begin
         wbin_sync[i] = ^(w_ptr_sync >> i);
      end
   end

   assign count_next = wbin_sync - rbin_next;

   always_ff @(posedge r_clk) begin
      if (!r_rst) begin
         rbin          <= '0;
         r_ptr         <= '0;
         rempty        <= 1'b1;
         ralmost_empty <= 1'b1;
         rcount        <= '0;
         runderflow    <= 1'b0;
      end else begin
         rbin          <= rbin_next;
         r_ptr         <= rgray_next;
         rempty        <= (rgray_next == w_ptr_sync);
         ralmost_empty <= (count_next <= AE_THRESH);
         rcount        <= count_next;
         // A new underflow outranks a clear presented in the same cycle.
         if (rinc && rempty) begin
            runderflow <= 1'b1;
         end else if (runderflow_clr) begin
            runderflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rd_contrl.sv
// Scoreboard bench for rd_contrl: a behavioural model pushes expected register
// state per edge; the state is popped and compared just after that edge.
module tb_rd_contrl;

   localparam int AW = 4;
   localparam int AE = 2;

   typedef struct {
      logic [AW:0]   ptr;
      logic [AW-1:0] addr;
      logic          empty;
      logic          ae;
      logic [AW:0]   cnt;
      logic          unf;
   } exp_t;

   logic          r_clk = 1'b0;
   logic          r_rst = 1'b1;
   logic          rinc = 1'b0;
   logic          runderflow_clr = 1'b0;
   logic [AW:0]   w_ptr_sync = '0;
   logic          rempty;
   logic          ralmost_empty;
   logic [AW:0]   rcount;
   logic          runderflow;
   logic [AW:0]   r_ptr;
   logic [AW-1:0] raddr;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb_q[$];
   exp_t cur;
   logic cur_valid = 1'b0;

   logic [AW:0] m_rbin = '0;
   logic        m_empty = 1'b1;
   logic        m_unf = 1'b0;

   rd_contrl #(.ADDR_WIDTH(AW), .AE_LEVEL(AE)) dut (
      .r_clk(r_clk), .r_rst(r_rst), .rinc(rinc), .rempty(rempty),
      .ralmost_empty(ralmost_empty), .rcount(rcount), .runderflow(runderflow),
      .runderflow_clr(runderflow_clr), .r_ptr(r_ptr), .w_ptr_sync(w_ptr_sync),
      .raddr(raddr)
   );

   always #5 r_clk = ~r_clk;

   function automatic logic [AW:0] gray(input logic [AW:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [AW:0] g2b(input logic [AW:0] g);
      logic [AW:0] b;
      b[AW] = g[AW];
      for (int k = AW - 1; k >= 0; k--) b[k] = b[k+1] ^ g[k];
      return b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, ".r_ptr"}, 32'(r_ptr), 32'(e.ptr));
      chk({tag, ".raddr"}, 32'(raddr), 32'(e.addr));
      chk({tag, ".rempty"}, 32'(rempty), 32'(e.empty));
      chk({tag, ".ralmost_empty"}, 32'(ralmost_empty), 32'(e.ae));
      chk({tag, ".rcount"}, 32'(rcount), 32'(e.cnt));
      chk({tag, ".runderflow"}, 32'(runderflow), 32'(e.unf));
   endtask

   // Drive one cycle at the falling edge, predict, then compare after the rising edge.
   task automatic step(input logic rst, input logic inc, input logic clr, input logic [AW:0] wp);
      exp_t        e;
      logic [AW:0] c;
      logic        p;
      @(negedge r_clk);
      r_rst = rst; rinc = inc; runderflow_clr = clr; w_ptr_sync = wp;
      #1;
      if (cur_valid) chk_all("hold", cur);
      if (!rst) begin
         m_rbin = '0; m_empty = 1'b1; m_unf = 1'b0; c = '0;
      end else begin
         p = inc & ~m_empty;
         if (inc && m_empty) m_unf = 1'b1;
         else if (clr) m_unf = 1'b0;
         m_rbin = m_rbin + {{AW{1'b0}}, p};
         c = g2b(wp) - m_rbin;
         m_empty = (c == 0);
      end
      e.ptr = gray(m_rbin); e.addr = m_rbin[AW-1:0]; e.empty = m_empty;
      e.ae = (int'(c) <= AE); e.cnt = c; e.unf = m_unf;
      sb_q.push_back(e);
      @(posedge r_clk);
      #1;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         cur = sb_q.pop_front();
         cur_valid = 1'b1;
         chk_all("post", cur);
      end
   endtask

   initial begin
      logic [AW:0] wb;
      // 1. reset with rinc high and a non-zero write pointer
      step(1'b0, 1'b1, 1'b0, 5'b00010);
      chk("rst.rempty", 32'(rempty), 32'd1);
      chk("rst.rcount", 32'(rcount), 32'd0);
      chk("rst.r_ptr", 32'(r_ptr), 32'd0);
      // 2. fill three, drain three
      step(1'b1, 1'b0, 1'b0, 5'b00010);
      chk("fill.rcount", 32'(rcount), 32'd3);
      chk("fill.ae", 32'(ralmost_empty), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 5'b00010);
      chk("drain.rempty", 32'(rempty), 32'd1);
      chk("drain.r_ptr", 32'(r_ptr), 32'b00010);
      // 3. wrap-around from rbin=0
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, 5'b11000);
      chk("wrap.rcount", 32'(rcount), 32'd16);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 5'b11000);
      chk("wrap.r_ptr", 32'(r_ptr), 32'b11000);
      chk("wrap.raddr", 32'(raddr), 32'd0);
      step(1'b1, 1'b0, 1'b0, 5'b11001);
      chk("wrap17.rcount", 32'(rcount), 32'd1);
      // 4. underflow: drain, pulse on empty, clear racing set, then clear alone
      step(1'b1, 1'b1, 1'b0, 5'b11001);
      step(1'b1, 1'b1, 1'b0, 5'b11001);
      chk("unf.set", 32'(runderflow), 32'd1);
      step(1'b1, 1'b0, 1'b0, 5'b11001);
      step(1'b1, 1'b1, 1'b1, 5'b11001);
      chk("unf.setwins", 32'(runderflow), 32'd1);
      step(1'b1, 1'b0, 1'b1, 5'b11001);
      chk("unf.clr", 32'(runderflow), 32'd0);
      // 5. pop and write-pointer step in the same cycle, starting at rcount=1
      step(1'b1, 1'b0, 1'b0, gray(5'd18));
      step(1'b1, 1'b1, 1'b0, gray(5'd19));
      chk("simul.rcount", 32'(rcount), 32'd1);
      chk("simul.rempty", 32'(rempty), 32'd0);
      // randomised traffic keeping occupancy within depth
      wb = 5'd19;
      for (int i = 0; i < 60; i++) begin
         logic [AW:0] occ;
         logic [1:0]  adv;
         occ = wb - m_rbin;
         adv = 2'($urandom_range(0, 2));
         if (int'(occ) + int'(adv) <= 16) wb = wb + {3'b000, adv};
         step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), gray(wb));
      end
      // 6. reset mid-operation with rcount=5
      step(1'b1, 1'b0, 1'b0, gray(m_rbin + 5'd5));
      chk("mid.rcount", 32'(rcount), 32'd5);
      step(1'b0, 1'b1, 1'b0, gray(m_rbin + 5'd5));
      chk("mid.rst.rcount", 32'(rcount), 32'd0);
      step(1'b1, 1'b0, 1'b0, gray(5'd5));
      chk("mid.after.rcount", 32'(rcount), 32'd5);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout tests=%0d", n_tests);
      $fatal(1, "timeout");
   end

endmodule
